// File: rtl/mem_bridge_if.sv
//------------------------------------------------------------------------------
// mem_bridge_if : request-side and physical-memory-side signals of mem_bridge
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_bridge_if;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        req_resp;
    logic [31:0] req_rdata;
    logic        req_err;

    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic        pmem_resp;
    logic [31:0] pmem_rdata;

    // The bridge itself
    modport slave (
        input  req_read, req_write, req_address, req_wdata, req_funct3,
        output req_resp, req_rdata, req_err,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        input  pmem_resp, pmem_rdata
    );

    // Control unit plus memory model surrounding the bridge
    modport master (
        output req_read, req_write, req_address, req_wdata, req_funct3,
        input  req_resp, req_rdata, req_err,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        output pmem_resp, pmem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_bridge.sv
//------------------------------------------------------------------------------
// mem_bridge : single-transaction bridge from CPU load/store control to memory.
// Optional access timeout enabled by defining MEM_BRIDGE_TIMEOUT_EN.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    mem_bridge_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_accept;
    logic        w_complete;
    logic        w_timeout;
    logic [3:0]  w_be;

    logic        r_pmem_read;
    logic        r_pmem_write;
    logic [31:0] r_pmem_address;
    logic [31:0] r_pmem_wdata;
    logic [3:0]  r_pmem_be;
    logic [31:0] r_rdata;
    logic        r_resp;

    // Lane mask; a simultaneous read+write request is treated as a write
    always_comb begin
        w_be = 4'b1111;
        if (bus.req_write) begin
            case (bus.req_funct3)
                3'b000:  w_be = 4'b0001 << bus.req_address[1:0];
                3'b001:  w_be = bus.req_address[1] ? 4'b1100 : 4'b0011;
                default: w_be = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_read || bus.req_write) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (bus.pmem_resp || w_timeout) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_cnt <= 8'd0;
        else if (w_accept)             r_cnt <= 8'd0;
        else if (r_state == ST_ACCESS) r_cnt <= r_cnt + 8'd1;
    end

    // r_cnt holds the number of ACCESS cycles already elapsed
    assign w_timeout = (r_state == ST_ACCESS) && (r_cnt == c_TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= w_complete && !bus.pmem_resp;
    end

    assign bus.req_err = r_err;
`else
    assign w_timeout   = 1'b0;
    assign bus.req_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= 32'd0;
            r_pmem_wdata   <= 32'd0;
            r_pmem_be      <= 4'd0;
            r_rdata        <= 32'd0;
            r_resp         <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            if (w_accept) begin
                r_pmem_read    <= !bus.req_write;
                r_pmem_write   <= bus.req_write;
                r_pmem_address <= {bus.req_address[31:2], 2'b00};
                r_pmem_wdata   <= bus.req_wdata;
                r_pmem_be      <= w_be;
            end
            if (w_complete) begin
                r_pmem_read  <= 1'b0;
                r_pmem_write <= 1'b0;
                r_resp       <= 1'b1;
                if (bus.pmem_resp) begin
                    if (r_pmem_read) r_rdata <= bus.pmem_rdata;
                end else begin
                    r_rdata <= 32'd0;
                end
            end
        end
    end

    assign bus.pmem_read        = r_pmem_read;
    assign bus.pmem_write       = r_pmem_write;
    assign bus.pmem_address     = r_pmem_address;
    assign bus.pmem_wdata       = r_pmem_wdata;
    assign bus.pmem_byte_enable = r_pmem_be;
    assign bus.req_rdata        = r_rdata;
    assign bus.req_resp         = r_resp;

endmodule

`default_nettype wire

// File: tb/tb_mem_bridge.sv
//------------------------------------------------------------------------------
// tb_mem_bridge : randomized self-checking bench for mem_bridge
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_bridge;

    localparam int TO = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [31:0] model_rdata;

    mem_bridge_if bus ();

    mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] strobes();
        return {30'd0, bus.pmem_write, bus.pmem_read};
    endfunction

    // One complete transaction; memory answers on ACCESS cycle 'lat' (0 = never)
    task automatic do_txn(input string tag, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wdata, input int lat,
                          input logic [31:0] mdata);
        logic [31:0] exp_addr;
        logic [31:0] exp_be;
        logic [31:0] exp_strb;
        int size;
        int off;
        int e;
        bit to;
        exp_addr = addr & 32'hFFFF_FFFC;
        if (wr) begin
            size   = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
            off    = (int'(addr % 4) / size) * size;
            exp_be = 32'(((1 << size) - 1) << off);
        end else begin
            exp_be = 32'hF;
        end
        exp_strb = wr ? 32'd2 : 32'd1;
        to = 1'b0;
        e  = lat;
`ifdef MEM_BRIDGE_TIMEOUT_EN
        if (lat == 0 || lat > TO) begin
            to = 1'b1;
            e  = TO;
        end
`endif
        @(negedge clk);
        bus.req_read    = rd;
        bus.req_write   = wr;
        bus.req_address = addr;
        bus.req_funct3  = f3;
        bus.req_wdata   = wdata;
        for (int i = 1; i <= e; i++) begin
            @(negedge clk);
            check({tag, ".strobe"}, strobes(), exp_strb);
            check({tag, ".addr"},   bus.pmem_address, exp_addr);
            check({tag, ".be"},     32'(bus.pmem_byte_enable), exp_be);
            check({tag, ".wdata"},  bus.pmem_wdata, wdata);
            check({tag, ".noresp"}, 32'(bus.req_resp), 32'd0);
            bus.req_read    = 1'($urandom);
            bus.req_write   = 1'($urandom);
            bus.req_address = $urandom;
            bus.req_funct3  = 3'($urandom);
            bus.req_wdata   = $urandom;
            bus.pmem_resp   = (i == lat);
            bus.pmem_rdata  = (i == lat) ? mdata : $urandom;
        end
        @(negedge clk);
        if (to)            model_rdata = 32'd0;
        else if (!wr)      model_rdata = mdata;
        check({tag, ".resp"},   32'(bus.req_resp), 32'd1);
        check({tag, ".err"},    32'(bus.req_err), 32'(to));
        check({tag, ".rdata"},  bus.req_rdata, model_rdata);
        check({tag, ".dstrb"},  strobes(), 32'd0);
        bus.pmem_resp = 1'b1;
        bus.req_read  = 1'b1;
        bus.req_write = 1'b1;
        @(negedge clk);
        check({tag, ".resp1"},  32'(bus.req_resp), 32'd0);
        check({tag, ".istrb"},  strobes(), 32'd0);
        check({tag, ".hold"},   bus.req_rdata, model_rdata);
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        bus.pmem_resp = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".strb"},  strobes(), 32'd0);
        check({tag, ".addr"},  bus.pmem_address, 32'd0);
        check({tag, ".wdata"}, bus.pmem_wdata, 32'd0);
        check({tag, ".be"},    32'(bus.pmem_byte_enable), 32'd0);
        check({tag, ".rdata"}, bus.req_rdata, 32'd0);
        check({tag, ".resp"},  32'(bus.req_resp), 32'd0);
        check({tag, ".err"},   32'(bus.req_err), 32'd0);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        model_rdata     = 32'd0;
        rst_n           = 1'b0;
        bus.req_read    = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_address = 32'd0;
        bus.req_wdata   = 32'd0;
        bus.req_funct3  = 3'd0;
        bus.pmem_resp   = 1'b0;
        bus.pmem_rdata  = 32'd0;

        repeat (2) @(negedge clk);
        check_all_zero("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        do_txn("rd106",  1, 0, 32'h0000_0106, 3'd2, 32'h1234_5678, 3, 32'hDEAD_BEEF);
        do_txn("sb13",   0, 1, 32'h0000_0013, 3'd0, 32'hAB00_0000, 2, 32'h5555_5555);
        do_txn("sh23",   0, 1, 32'h0000_0023, 3'd1, 32'hCDEF_0000, 1, 32'h6666_6666);
        do_txn("sw20",   0, 1, 32'h0000_0020, 3'd2, 32'h0102_0304, 2, 32'h7777_7777);
        do_txn("sbodd",  0, 1, 32'h0000_0041, 3'd0, 32'h0000_5A00, 1, 32'h0);
        do_txn("f3oth",  0, 1, 32'h0000_0042, 3'd7, 32'hFFFF_0000, 1, 32'h0);
        do_txn("rdwr",   1, 1, 32'h0000_0031, 3'd0, 32'h0000_CC00, 2, 32'h8888_8888);
        do_txn("rd2",    1, 0, 32'hFFFF_FFFF, 3'd0, 32'h0,         1, 32'hCAFE_F00D);

`ifdef MEM_BRIDGE_TIMEOUT_EN
        do_txn("tmo",    1, 0, 32'h0000_0200, 3'd2, 32'h0,         0, 32'h0);
        do_txn("rd3",    1, 0, 32'h0000_0204, 3'd2, 32'h0,         2, 32'h1357_9BDF);
        do_txn("tmow",   0, 1, 32'h0000_0208, 3'd2, 32'h2468_ACE0, 0, 32'h0);
        do_txn("edge",   1, 0, 32'h0000_0300, 3'd2, 32'h0,         TO, 32'hA5A5_5A5A);
`else
        do_txn("slow",   1, 0, 32'h0000_0300, 3'd2, 32'h0,         12, 32'hA5A5_5A5A);
`endif

        // Reset pulse in the middle of an ACCESS
        @(negedge clk);
        bus.req_read    = 1'b1;
        bus.req_address = 32'h0000_0400;
        @(negedge clk);
        check("mid.strb", strobes(), 32'd1);
        bus.req_read = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_rdata = 32'd0;
        check_all_zero("mid");
        for (int i = 0; i < 3; i++) begin
            bus.pmem_resp = 1'b1;
            @(negedge clk);
            check("mid.noresp", 32'(bus.req_resp), 32'd0);
        end
        bus.pmem_resp = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_txn("postrst", 1, 0, 32'h0000_0404, 3'd2, 32'h0, 2, 32'h0BAD_CAFE);

        for (int k = 0; k < 30; k++) begin
            int op;
            op = int'($urandom_range(0, 2));
            do_txn("rnd", op != 1, op != 0, $urandom, 3'($urandom_range(0, 7)),
                   $urandom, int'($urandom_range(1, 6)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, which is the maximum number of ACCESS cycles before an abort when MEM_BRIDGE_TIMEOUT_EN is defined.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port req_read, input, 1 bit, the load request from control.
REQ-005 The block SHALL have port req_write, input, 1 bit, the store request from control.
REQ-006 The block SHALL have port req_address, input, 32 bits, the byte address taken from the datapath MAR.
REQ-007 The block SHALL have port req_wdata, input, 32 bits, store data already lane-shifted by the datapath.
REQ-008 The block SHALL have port req_funct3, input, 3 bits, the store width (000 = SB, 001 = SH, 010 = SW).
REQ-009 The block SHALL have port req_resp, output, 1 bit, a one-cycle completion pulse.
REQ-010 The block SHALL have port req_rdata, output, 32 bits, the full read word (MDR input).
REQ-011 The block SHALL have port req_err, output, 1 bit, a timeout flag valid with req_resp.
REQ-012 The block SHALL have ports pmem_read and pmem_write, output, 1 bit each, the physical memory strobes.
REQ-013 The block SHALL have port pmem_address, output, 32 bits, the word-aligned address.
REQ-014 The block SHALL have port pmem_wdata, output, 32 bits, the write data.
REQ-015 The block SHALL have port pmem_byte_enable, output, 4 bits, the lane mask.
REQ-016 The block SHALL have port pmem_resp, input, 1 bit, memory completion.
REQ-017 The block SHALL have port pmem_rdata, input, 32 bits, memory read data, valid when pmem_resp is high.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-019 In IDLE with req_read or req_write high, the block SHALL register the address, wdata, byte mask and direction, then move to ACCESS.
REQ-020 When req_read and req_write are both high in IDLE, the block SHALL perform the write only.
REQ-021 pmem_read or pmem_write SHALL assert from the first ACCESS cycle, giving one cycle of latency after the request, and SHALL stay high with all pmem outputs stable until pmem_resp.
REQ-022 pmem_address SHALL equal the registered address with bits [1:0] forced to 00.
REQ-023 The write byte mask SHALL be 0001<<addr[1:0] for SB, 0011<<{addr[1],0} for SH (addr[0] ignored), and 1111 for SW or any other funct3.
REQ-024 The read byte mask SHALL be 1111.
REQ-025 On an ACCESS cycle with pmem_resp high, the block SHALL register pmem_rdata (reads only), deassert the strobes the next cycle and move to DONE.
REQ-026 In DONE, req_resp SHALL be 1 for exactly one cycle, req_rdata SHALL hold the captured word, and the next state SHALL be IDLE.
REQ-027 Requests held high during DONE SHALL be ignored; control drops them on seeing req_resp.
REQ-028 req_rdata SHALL hold its value until the next read completes; after a write it SHALL be unchanged.
REQ-029 pmem_resp SHALL be ignored in IDLE and DONE.
REQ-030 Changes on req_* during ACCESS SHALL have no effect.

Reset
REQ-031 rst_n low SHALL immediately force IDLE and drive every output to 0, including req_rdata and pmem_byte_enable, with the timeout counter at 0.
REQ-032 Reset asserted mid-ACCESS SHALL drop the strobes asynchronously, abandon the transaction, and produce no req_resp.
REQ-033 After rst_n deasserts, the first request SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-034 With MEM_BRIDGE_TIMEOUT_EN defined, an 8-bit counter SHALL count ACCESS cycles; it SHALL clear on entry to ACCESS.
REQ-035 When the counter reaches TIMEOUT_CYCLES without pmem_resp, the block SHALL drop the strobes, set req_rdata to 0, and go to DONE with req_err=1 for the DONE cycle.
REQ-036 If pmem_resp arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the response SHALL win and req_err SHALL be 0.
REQ-037 Without MEM_BRIDGE_TIMEOUT_EN, the block SHALL have no counter, req_err SHALL be tied to 0, and ACCESS SHALL wait indefinitely.

Verification
REQ-038 The bench SHALL cover a read: req_read with address 0x00000106, memory responding on the 3rd ACCESS cycle with 0xDEADBEEF -> pmem_address=0x00000104, mask=1111, req_resp one cycle, req_rdata=0xDEADBEEF.
REQ-039 The bench SHALL cover an SB store to 0x00000013 with wdata 0xAB000000 -> pmem_write with mask=1000 and pmem_wdata=0xAB000000, then req_resp.
REQ-040 The bench SHALL cover an SH store to 0x00000023 -> mask=1100; an SW store to 0x00000020 -> mask=1111.
REQ-041 The bench SHALL cover req_read and req_write both high -> only pmem_write asserts.
REQ-042 The bench SHALL cover rst_n pulsed low during ACCESS -> strobes fall without waiting for clk, no req_resp, and a new read completes normally afterwards.
REQ-043 The bench SHALL cover, with MEM_BRIDGE_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, no pmem_resp -> strobes drop after 4 ACCESS cycles, req_resp with req_err=1 and req_rdata=0; and pmem_resp on the 4th cycle -> req_err=0.
